// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//   Execute-stage pipeline wrapper around the 16-bit alu. Decoded operands
//   arrive over a valid/ready handshake and are held in stage S1, which drives
//   the external alu combinationally. The alu result, destination and write
//   enable are captured in stage S2, which presents one writeback entry to the
//   register file. The stage also owns the PSR flag register {F,L,C,N,Z}.
//
// Ports
//   clk_i, rst_ni             clock (rising edge), async active-low reset
//   flush_i                   synchronous flush of both stages
//   in_valid_i / in_ready_o   upstream handshake
//   alu_sel_i, A_i, B_i       decoded op: mode code and operands
//   rdest_i, wb_en_i          writeback destination and enable
//   flags_en_i                op updates the PSR from the alu flags
//   alu_A_o/alu_B_o/alu_sel_o operands and mode to the alu (from S1)
//   alu_result_i/alu_flags_i  combinational alu response
//   out_valid_o / out_ready_i downstream handshake
//   wb_data_o/wb_rdest_o/wb_en_o registered writeback entry (S2)
//   psr_we_i / psr_wdata_i    explicit PSR write, wins over alu flag update
//   psr_flags_o               current PSR {F,L,C,N,Z}

module alu_exec_stage #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RADDR_W     = 4,
  parameter logic [4:0]  PSR_RESET   = 5'b0,
  parameter logic [5:0]  ALU_SEL_CMP = 6'b001011
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  // upstream (decode)
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [5:0]         alu_sel_i,
  input  logic [DATA_W-1:0]  A_i,
  input  logic [DATA_W-1:0]  B_i,
  input  logic [RADDR_W-1:0] rdest_i,
  input  logic               wb_en_i,
  input  logic               flags_en_i,
  // alu interface
  output logic [DATA_W-1:0]  alu_A_o,
  output logic [DATA_W-1:0]  alu_B_o,
  output logic [5:0]         alu_sel_o,
  input  logic [DATA_W-1:0]  alu_result_i,
  input  logic [4:0]         alu_flags_i,
  // downstream (writeback)
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DATA_W-1:0]  wb_data_o,
  output logic [RADDR_W-1:0] wb_rdest_o,
  output logic               wb_en_o,
  // PSR
  input  logic               psr_we_i,
  input  logic [4:0]         psr_wdata_i,
  output logic [4:0]         psr_flags_o
);

  // S1: operands and control
  logic               r_s1_valid;
  logic [5:0]         r_s1_sel;
  logic [DATA_W-1:0]  r_s1_a;
  logic [DATA_W-1:0]  r_s1_b;
  logic [RADDR_W-1:0] r_s1_rdest;
  logic               r_s1_wb_en;
  logic               r_s1_flags_en;

  // S2: result and control
  logic               r_s2_valid;
  logic [DATA_W-1:0]  r_s2_data;
  logic [RADDR_W-1:0] r_s2_rdest;
  logic               r_s2_wb_en;

  logic [4:0]         r_psr;

  logic               w_s2_free;
  logic               w_s1_move;
  logic               w_accept;
  logic               w_s1_wb_en_eff;

  // S2 can take a new entry when empty or when its entry leaves this cycle.
  assign w_s2_free  = !r_s2_valid || out_ready_i;
  assign w_s1_move  = r_s1_valid && w_s2_free;
  assign in_ready_o = !r_s1_valid || w_s2_free;
  assign w_accept   = in_valid_i && in_ready_o;

  // Compares only produce flags; they never write a destination register.
  assign w_s1_wb_en_eff = r_s1_wb_en && (r_s1_sel != ALU_SEL_CMP);

  // S1 register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid    <= 1'b0;
      r_s1_sel      <= '0;
      r_s1_a        <= '0;
      r_s1_b        <= '0;
      r_s1_rdest    <= '0;
      r_s1_wb_en    <= 1'b0;
      r_s1_flags_en <= 1'b0;
    end else if (flush_i) begin
      // Any op accepted in the flush cycle is discarded.
      r_s1_valid    <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid    <= 1'b1;
      r_s1_sel      <= alu_sel_i;
      r_s1_a        <= A_i;
      r_s1_b        <= B_i;
      r_s1_rdest    <= rdest_i;
      r_s1_wb_en    <= wb_en_i;
      r_s1_flags_en <= flags_en_i;
    end else if (w_s1_move) begin
      r_s1_valid    <= 1'b0;
    end
  end

  // S2 register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_rdest <= '0;
      r_s2_wb_en <= 1'b0;
    end else if (flush_i) begin
      // Write enable is dropped too so a flushed entry cannot be mistaken
      // for a pending write by a consumer that ignores out_valid_o.
      r_s2_valid <= 1'b0;
      r_s2_wb_en <= 1'b0;
    end else if (w_s1_move) begin
      r_s2_valid <= 1'b1;
      r_s2_data  <= alu_result_i;
      r_s2_rdest <= r_s1_rdest;
      r_s2_wb_en <= w_s1_wb_en_eff;
    end else if (out_ready_i) begin
      r_s2_valid <= 1'b0;
    end
  end

  // PSR: explicit write wins; alu flags only when the op actually advances
  // and the pipeline is not being flushed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_psr <= PSR_RESET;
    end else if (psr_we_i) begin
      r_psr <= psr_wdata_i;
    end else if (w_s1_move && r_s1_flags_en && !flush_i) begin
      r_psr <= alu_flags_i;
    end
  end

  assign alu_A_o     = r_s1_a;
  assign alu_B_o     = r_s1_b;
  assign alu_sel_o   = r_s1_sel;

  assign out_valid_o = r_s2_valid;
  assign wb_data_o   = r_s2_data;
  assign wb_rdest_o  = r_s2_rdest;
  assign wb_en_o     = r_s2_wb_en;

  assign psr_flags_o = r_psr;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage
//   Directed-vector bench for alu_exec_stage. A small behavioural alu
//   (ADD/SUB/CMP) closes the loop on the alu interface; expected values
//   are hand-computed constants.

module tb_alu_exec_stage;

  localparam logic [5:0] SEL_ADD = 6'b000101;
  localparam logic [5:0] SEL_SUB = 6'b001001;
  localparam logic [5:0] SEL_CMP = 6'b001011;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [5:0]  alu_sel_i;
  logic [15:0] A_i;
  logic [15:0] B_i;
  logic [3:0]  rdest_i;
  logic        wb_en_i;
  logic        flags_en_i;
  logic [15:0] alu_A_o;
  logic [15:0] alu_B_o;
  logic [5:0]  alu_sel_o;
  logic [15:0] alu_result_i;
  logic [4:0]  alu_flags_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] wb_data_o;
  logic [3:0]  wb_rdest_o;
  logic        wb_en_o;
  logic        psr_we_i;
  logic [4:0]  psr_wdata_i;
  logic [4:0]  psr_flags_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk_i = ~clk_i;

  alu_exec_stage #(
    .DATA_W     (16),
    .RADDR_W    (4),
    .PSR_RESET  (5'b00000),
    .ALU_SEL_CMP(SEL_CMP)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .alu_sel_i   (alu_sel_i),
    .A_i         (A_i),
    .B_i         (B_i),
    .rdest_i     (rdest_i),
    .wb_en_i     (wb_en_i),
    .flags_en_i  (flags_en_i),
    .alu_A_o     (alu_A_o),
    .alu_B_o     (alu_B_o),
    .alu_sel_o   (alu_sel_o),
    .alu_result_i(alu_result_i),
    .alu_flags_i (alu_flags_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .wb_data_o   (wb_data_o),
    .wb_rdest_o  (wb_rdest_o),
    .wb_en_o     (wb_en_o),
    .psr_we_i    (psr_we_i),
    .psr_wdata_i (psr_wdata_i),
    .psr_flags_o (psr_flags_o)
  );

  // Behavioural alu. Flags {F,L,C,N,Z}: F signed overflow, L signed A<B,
  // C carry (add) or borrow (sub/cmp), N sign, Z zero.
  logic [16:0] m_wide;
  logic [15:0] m_res;
  logic        m_f, m_l, m_c;
  always_comb begin
    m_wide = '0;
    m_res  = '0;
    m_f    = 1'b0;
    m_l    = 1'b0;
    m_c    = 1'b0;
    case (alu_sel_o)
      SEL_ADD: begin
        m_wide = {1'b0, alu_A_o} + {1'b0, alu_B_o};
        m_res  = m_wide[15:0];
        m_c    = m_wide[16];
        m_f    = (alu_A_o[15] == alu_B_o[15]) && (m_res[15] != alu_A_o[15]);
      end
      SEL_SUB, SEL_CMP: begin
        m_wide = {1'b0, alu_A_o} - {1'b0, alu_B_o};
        m_res  = m_wide[15:0];
        m_c    = alu_A_o < alu_B_o;
        m_l    = $signed(alu_A_o) < $signed(alu_B_o);
        m_f    = (alu_A_o[15] != alu_B_o[15]) && (m_res[15] != alu_A_o[15]);
      end
      default: ;
    endcase
  end
  assign alu_result_i = m_res;
  assign alu_flags_i  = {m_f, m_l, m_c, m_res[15], (m_res == 16'h0000)};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_op(input logic [5:0] sel, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] rd, input logic wb, input logic fe);
    in_valid_i = 1'b1;
    alu_sel_i  = sel;
    A_i        = a;
    B_i        = b;
    rdest_i    = rd;
    wb_en_i    = wb;
    flags_en_i = fe;
  endtask

  initial begin
    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    alu_sel_i   = '0;
    A_i         = '0;
    B_i         = '0;
    rdest_i     = '0;
    wb_en_i     = 1'b0;
    flags_en_i  = 1'b0;
    out_ready_i = 1'b1;
    psr_we_i    = 1'b0;
    psr_wdata_i = '0;

    // T1: reset state
    tick();
    tick();
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_in_ready",  in_ready_o,  1'b1);
    check("rst_psr",       psr_flags_o, 5'b00000);
    check("rst_wb_data",   wb_data_o,   16'h0000);
    check("rst_wb_en",     wb_en_o,     1'b0);
    check("rst_alu_a",     alu_A_o,     16'h0000);
    rst_ni = 1'b1;
    tick();

    // T1: reset mid-operation drops ops and restores PSR
    psr_we_i    = 1'b1;
    psr_wdata_i = 5'b11111;
    set_op(SEL_ADD, 16'h0010, 16'h0020, 4'd7, 1'b1, 1'b0);
    tick();
    psr_we_i = 1'b0;
    tick();
    in_valid_i = 1'b0;
    check("mid_psr_written", psr_flags_o, 5'b11111);
    check("mid_out_valid",   out_valid_o, 1'b1);
    rst_ni = 1'b0;
    #2;
    check("mid_rst_out_valid", out_valid_o, 1'b0);
    check("mid_rst_psr",       psr_flags_o, 5'b00000);
    tick();
    rst_ni = 1'b1;
    tick();
    check("mid_rel_in_ready",  in_ready_o,  1'b1);
    check("mid_rel_out_valid", out_valid_o, 1'b0);

    // T2: ADD 0xFFFF + 0x0001 -> 0, C and Z set
    set_op(SEL_ADD, 16'hFFFF, 16'h0001, 4'd3, 1'b1, 1'b1);
    tick();
    in_valid_i = 1'b0;
    check("add_s1_only",  out_valid_o, 1'b0);
    check("add_alu_a",    alu_A_o,     16'hFFFF);
    tick();
    check("add_valid",    out_valid_o, 1'b1);
    check("add_data",     wb_data_o,   16'h0000);
    check("add_rdest",    wb_rdest_o,  4'd3);
    check("add_wb_en",    wb_en_o,     1'b1);
    check("add_psr",      psr_flags_o, 5'b00101);
    tick();
    check("add_drained",  out_valid_o, 1'b0);

    // T3: CMP suppresses writeback but updates flags
    set_op(SEL_CMP, 16'h0005, 16'h0005, 4'd4, 1'b1, 1'b1);
    tick();
    set_op(SEL_ADD, 16'h0001, 16'h0002, 4'd5, 1'b1, 1'b0);
    tick();
    in_valid_i = 1'b0;
    check("cmp_valid", out_valid_o, 1'b1);
    check("cmp_wb_en", wb_en_o,     1'b0);
    check("cmp_psr",   psr_flags_o, 5'b00001);
    tick();
    check("add_nf_data",  wb_data_o,   16'h0003);
    check("add_nf_wb_en", wb_en_o,     1'b1);
    check("add_nf_psr",   psr_flags_o, 5'b00001);
    tick();

    // T4: back-to-back ops with downstream stall
    out_ready_i = 1'b0;
    set_op(SEL_ADD, 16'h0001, 16'h0001, 4'd1, 1'b1, 1'b0);
    tick();
    set_op(SEL_ADD, 16'h0002, 16'h0002, 4'd2, 1'b1, 1'b0);
    tick();
    check("bb_full_in_ready", in_ready_o,  1'b0);
    check("bb_first_data",    wb_data_o,   16'h0002);
    set_op(SEL_ADD, 16'h0003, 16'h0003, 4'd3, 1'b1, 1'b0);
    tick();
    check("bb_stall1_data",  wb_data_o,  16'h0002);
    check("bb_stall1_rdest", wb_rdest_o, 4'd1);
    check("bb_stall1_ready", in_ready_o, 1'b0);
    tick();
    check("bb_stall2_data",  wb_data_o,   16'h0002);
    check("bb_stall2_valid", out_valid_o, 1'b1);
    out_ready_i = 1'b1;
    #1;
    check("bb_release_ready", in_ready_o, 1'b1);
    tick();
    check("bb_op1_data",  wb_data_o,  16'h0004);
    check("bb_op1_rdest", wb_rdest_o, 4'd2);
    set_op(SEL_ADD, 16'h0004, 16'h0004, 4'd4, 1'b1, 1'b0);
    tick();
    in_valid_i = 1'b0;
    check("bb_op2_data",  wb_data_o,  16'h0006);
    check("bb_op2_rdest", wb_rdest_o, 4'd3);
    tick();
    check("bb_op3_data",  wb_data_o,  16'h0008);
    check("bb_op3_rdest", wb_rdest_o, 4'd4);
    tick();
    check("bb_drained", out_valid_o, 1'b0);

    // T5: flush with both stages full and a new op offered
    out_ready_i = 1'b0;
    set_op(SEL_ADD, 16'h0001, 16'h0001, 4'd6, 1'b1, 1'b0);
    tick();
    set_op(SEL_ADD, 16'h8000, 16'h8000, 4'd7, 1'b1, 1'b1);
    tick();
    check("fl_pre_valid", out_valid_o, 1'b1);
    out_ready_i = 1'b1;
    flush_i     = 1'b1;
    set_op(SEL_ADD, 16'h0009, 16'h0009, 4'd8, 1'b1, 1'b1);
    tick();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    check("fl_out_valid", out_valid_o, 1'b0);
    check("fl_wb_en",     wb_en_o,     1'b0);
    check("fl_psr",       psr_flags_o, 5'b00001);
    tick();
    check("fl_discarded", out_valid_o, 1'b0);
    check("fl_psr_after", psr_flags_o, 5'b00001);

    // T6: explicit PSR write beats a flag-updating SUB
    set_op(SEL_SUB, 16'h0003, 16'h0005, 4'd9, 1'b1, 1'b1);
    tick();
    in_valid_i  = 1'b0;
    psr_we_i    = 1'b1;
    psr_wdata_i = 5'b10101;
    tick();
    psr_we_i = 1'b0;
    check("psrw_psr",  psr_flags_o, 5'b10101);
    check("psrw_data", wb_data_o,   16'hFFFE);
    tick();
    set_op(SEL_SUB, 16'h0003, 16'h0005, 4'd9, 1'b1, 1'b1);
    tick();
    in_valid_i = 1'b0;
    tick();
    check("sub_psr", psr_flags_o, 5'b01110);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
